// File: rtl/rps_pkg.sv
// rps_pkg -- shared definitions for the rock/paper/scissors display controller.
//
// Holds the gesture encodings, the winner ids, the blank digit code, the
// controller state enum and the win/lose evaluation function.
package rps_pkg;

  // Gesture encodings as presented on p1_choice / p2_choice
  localparam logic [1:0] G_NONE     = 2'd0;
  localparam logic [1:0] G_ROCK     = 2'd1;
  localparam logic [1:0] G_SCISSORS = 2'd2;
  localparam logic [1:0] G_PAPER    = 2'd3;

  // Winner ids, also used directly as the displayed digit value
  localparam logic [1:0] WIN_DRAW = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  // Digit code that the segment driver renders as an unlit digit
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_SHOW,
    S_RESULT,
    S_OVER
  } state_t;

  // A player who shows nothing loses to any real gesture; two empty hands
  // and two identical gestures are both draws.
  function automatic logic [1:0] rps_winner(input logic [1:0] g1,
                                            input logic [1:0] g2);
    logic p1_beats;
    p1_beats = ((g1 == G_ROCK)     && (g2 == G_SCISSORS)) ||
               ((g1 == G_SCISSORS) && (g2 == G_PAPER))    ||
               ((g1 == G_PAPER)    && (g2 == G_ROCK));
    if (g1 == g2)          return WIN_DRAW;
    else if (g1 == G_NONE) return WIN_P2;
    else if (g2 == G_NONE) return WIN_P1;
    else if (p1_beats)     return WIN_P1;
    else                   return WIN_P2;
  endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer -- display step divider.
//
// Counts clk cycles 0..TICK_DIV-1 and raises step during the last count,
// so step is high for one cycle out of every TICK_DIV.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active low
//   clear in   restart the count from 0 (a new round begins)
//   step  out  one-cycle pulse every TICK_DIV cycles
module step_timer #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic step
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;

  assign step = (count == CW'(TICK_DIV - 1));

  // clear wins over wrap so the first step of a round lands exactly
  // TICK_DIV cycles after the start is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || step) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/display_ctrl.sv
// display_ctrl -- two-player rock/paper/scissors round sequencer and
// two-digit display driver.
//
// A round runs COUNT (3, 2, 1 countdown) -> SHOW (both gestures, 2 steps)
// -> RESULT (winner blinks, 4 steps), then the winner's score is bumped and
// the block returns to IDLE, or to OVER once a score reaches WIN_SCORE.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   request a round (honoured in IDLE and OVER only)
//   p1_choice  in   player 1 gesture (0 none, 1 rock, 2 scissors, 3 paper)
//   p2_choice  in   player 2 gesture
//   num1       out  left digit code, 4'hF = blank
//   num2       out  right digit code, 4'hF = blank
//   busy       out  high while a round is in progress
//   score1     out  player 1 score
//   score2     out  player 2 score
//   game_over  out  high while in OVER
module display_ctrl
  import rps_pkg::*;
#(
  parameter int TICK_DIV  = 1000,
  parameter int WIN_SCORE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] p1_choice,
  input  logic [1:0] p2_choice,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic       busy,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over
);

  localparam logic [3:0] WIN4 = 4'(WIN_SCORE);

  state_t     state, state_nxt;
  logic [1:0] phase, phase_nxt;
  logic [1:0] choice1, choice1_nxt;
  logic [1:0] choice2, choice2_nxt;
  logic [3:0] score1_nxt, score2_nxt;
  logic [3:0] num1_nxt, num2_nxt;
  logic       busy_nxt, game_over_nxt;
  logic [1:0] round_winner;
  logic [1:0] disp_winner;
  logic       accept;
  logic       step;

  assign accept       = start && ((state == S_IDLE) || (state == S_OVER));
  assign round_winner = rps_winner(choice1, choice2);

  step_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_step_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .step  (step)
  );

  // State register plus every output; outputs are loaded from the decoded
  // next-state values so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      phase     <= '0;
      choice1   <= '0;
      choice2   <= '0;
      score1    <= '0;
      score2    <= '0;
      num1      <= '0;
      num2      <= '0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      choice1   <= choice1_nxt;
      choice2   <= choice2_nxt;
      score1    <= score1_nxt;
      score2    <= score2_nxt;
      num1      <= num1_nxt;
      num2      <= num2_nxt;
      busy      <= busy_nxt;
      game_over <= game_over_nxt;
    end
  end

  // Next state. phase counts steps within the current state: countdown
  // position in COUNT, step index in SHOW/RESULT, blink half in OVER.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    choice1_nxt = choice1;
    choice2_nxt = choice2;
    score1_nxt  = score1;
    score2_nxt  = score2;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_COUNT;
          phase_nxt = '0;
        end
      end
      S_COUNT: begin
        if (step) begin
          if (phase == 2'd2) begin
            state_nxt   = S_SHOW;
            phase_nxt   = '0;
            choice1_nxt = p1_choice;
            choice2_nxt = p2_choice;
          end else begin
            phase_nxt = phase + 2'd1;
          end
        end
      end
      S_SHOW: begin
        if (step) begin
          if (phase == 2'd1) begin
            state_nxt = S_RESULT;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase + 2'd1;
          end
        end
      end
      S_RESULT: begin
        if (step) begin
          if (phase == 2'd3) begin
            // the < guard keeps a score from ever passing WIN_SCORE
            if ((round_winner == WIN_P1) && (score1 < WIN4)) begin
              score1_nxt = score1 + 4'd1;
            end
            if ((round_winner == WIN_P2) && (score2 < WIN4)) begin
              score2_nxt = score2 + 4'd1;
            end
            phase_nxt = '0;
            if ((score1_nxt == WIN4) || (score2_nxt == WIN4)) begin
              state_nxt = S_OVER;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            phase_nxt = phase + 2'd1;
          end
        end
      end
      S_OVER: begin
        if (accept) begin
          state_nxt  = S_COUNT;
          phase_nxt  = '0;
          score1_nxt = '0;
          score2_nxt = '0;
        end else if (step) begin
          phase_nxt = {1'b0, ~phase[0]};
        end
      end
      default: begin
        state_nxt = S_IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  // Output decode from the next-state values. The registered choices are
  // stable from SHOW until the next round's SHOW, so the winner derived
  // from them is still valid while blinking in OVER.
  always_comb begin
    disp_winner   = rps_winner(choice1_nxt, choice2_nxt);
    num1_nxt      = score1_nxt;
    num2_nxt      = score2_nxt;
    busy_nxt      = 1'b0;
    game_over_nxt = 1'b0;
    unique case (state_nxt)
      S_IDLE: begin
        num1_nxt = score1_nxt;
        num2_nxt = score2_nxt;
      end
      S_COUNT: begin
        num1_nxt = 4'd3 - {2'b00, phase_nxt};
        num2_nxt = BLANK;
        busy_nxt = 1'b1;
      end
      S_SHOW: begin
        num1_nxt = {2'b00, choice1_nxt};
        num2_nxt = {2'b00, choice2_nxt};
        busy_nxt = 1'b1;
      end
      S_RESULT: begin
        num1_nxt = phase_nxt[0] ? BLANK : {2'b00, disp_winner};
        num2_nxt = phase_nxt[0] ? BLANK : {2'b00, disp_winner};
        busy_nxt = 1'b1;
      end
      S_OVER: begin
        num1_nxt      = phase_nxt[0] ? BLANK : {2'b00, disp_winner};
        num2_nxt      = phase_nxt[0] ? BLANK : {2'b00, disp_winner};
        game_over_nxt = 1'b1;
      end
      default: begin
        num1_nxt = score1_nxt;
        num2_nxt = score2_nxt;
      end
    endcase
  end

endmodule

// File: doc/display_ctrl.md
DISPLAY_CTRL -- requirements
Module: display_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1000, meaning clk cycles per display step (minimum 2).
REQ-002 The block SHALL have parameter WIN_SCORE, default 3, meaning the score that ends a match (1..9).
REQ-003 The block SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port start  input  1  request a round; level-sampled, 1-cycle pulse sufficient.
REQ-006 The block SHALL have port p1_choice  input  2  player 1 gesture: 0 none, 1 rock, 2 scissors, 3 paper.
REQ-007 The block SHALL have port p2_choice  input  2  player 2 gesture, same encoding.
REQ-008 The block SHALL have port num1  output  4  left digit code to segment; 4'hF = blank.
REQ-009 The block SHALL have port num2  output  4  right digit code to segment; 4'hF = blank.
REQ-010 The block SHALL have port busy  output  1  high while a round is in progress.
REQ-011 The block SHALL have port score1  output  4  player 1 score.
REQ-012 The block SHALL have port score2  output  4  player 2 score.
REQ-013 The block SHALL have port game_over  output  1  high while in OVER.

Function
REQ-014 The block SHALL generate the step pulse internally: counter 0..TICK_DIV-1, step when count = TICK_DIV-1; counter cleared on start acceptance.
REQ-015 The block SHALL implement states IDLE, COUNT, SHOW, RESULT, OVER.
REQ-016 In IDLE the block SHALL drive num1 = score1, num2 = score2, busy = 0.
REQ-017 The block SHALL accept start only in IDLE or OVER; start while busy SHALL be ignored.
REQ-018 In OVER, start SHALL clear both scores and enter COUNT, as a new match.
REQ-019 On accepted start the block SHALL enter COUNT the next cycle with num1 = 3, num2 = 4'hF, busy = 1.
REQ-020 COUNT SHALL decrement num1 3 -> 2 -> 1, one step each, then enter SHOW.
REQ-021 At the COUNT->SHOW edge the block SHALL register p1_choice and p2_choice; later input changes SHALL have no effect on that round.
REQ-022 SHOW SHALL last 2 steps with num1 = registered p1 choice and num2 = registered p2 choice (0 shown as 0).
REQ-023 The outcome SHALL be: rock beats scissors, scissors beats paper, paper beats rock; equal gestures draw; one player 0 loses; both 0 draw.
REQ-024 RESULT SHALL last 4 steps, showing the winner id (1 or 2, 0 for draw) on both digits in steps 0 and 2, and 4'hF on both digits in steps 1 and 3.
REQ-025 On RESULT exit the block SHALL increment the winner's score by 1; a draw SHALL change neither score.
REQ-026 After the increment, a score equal to WIN_SCORE SHALL enter OVER; otherwise the block SHALL enter IDLE.
REQ-027 In OVER the block SHALL blink the winner id on both digits: one step shown, one step 4'hF, repeating; game_over = 1, busy = 0.
REQ-028 A score SHALL never exceed WIN_SCORE.
REQ-029 All outputs SHALL be registered.
REQ-030 Round latency SHALL be exactly 9*TICK_DIV cycles from the start-accept edge to the RESULT exit edge.

Reset
REQ-031 While rst = 0 the block SHALL force IDLE, step counter 0, scores 0, registered choices 0, num1 = 0, num2 = 0, busy = 0, game_over = 0.
REQ-032 Asserting rst mid-round SHALL abort the round immediately, with no score update.
REQ-033 Deasserting rst SHALL start operation at the first rising clk edge after deassertion.

Structure
REQ-034 The shared package rps_pkg SHALL hold the gesture encodings, the state enum, the winner ids, and the BLANK = 4'hF constant.
REQ-035 The step divider SHALL be the sub-module step_timer (ports clk, rst, clear, step).
REQ-036 Win/lose evaluation SHALL be a function in rps_pkg.

Verification (TICK_DIV = 4, WIN_SCORE = 3)
REQ-037 Scenario: start pulse in IDLE -> busy rises after 1 cycle; num1 shows 3, 2, 1, each for 4 cycles; num2 = F throughout.
REQ-038 Scenario: p1 = 1 (rock), p2 = 2 (scissors) held at the COUNT->SHOW edge -> SHOW shows 1/2; RESULT blinks 1/1, F/F, 1/1, F/F; score1 = 1, score2 = 0; IDLE is reached 36 cycles after start accept.
REQ-039 Scenario: p1 = 3, p2 = 3 -> RESULT shows 0/0 blinking; scores unchanged.
REQ-040 Scenario: p1 = 0, p2 = 3, then p1 changed to 1 during SHOW -> player 2 wins; score2 increments.
REQ-041 Scenario: three player-2 wins -> game_over = 1; digits alternate 2/2 and F/F every 4 cycles; start then clears the scores and gives num1 = 3.
REQ-042 Scenario: rst pulled low during RESULT, with start also pulsed while busy -> the ignored start has no effect; after reset, scores = 0, busy = 0, IDLE shows 0/0.
